handshake_tx_src: RTL and testbench

HANDSHAKE_TX_SRC -- requirements
Module: handshake_tx_src

---
 rtl/handshake_tx_src.sv | 135 +++++++++++++
 tb/tb_handshake_tx_src.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_tx_src.sv
// rtl/handshake_tx_src.sv - four-phase request source with ack synchronizer, REQ timeout and transfer counter
`timescale 1ns/1ps
module handshake_tx_src #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk_src,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  ack_dest,
    output logic                  req_src,
    output logic [DATA_WIDTH-1:0] data_src,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [7:0]            xfer_count
);

    localparam int SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int T_LAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_LAST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [SYNC_N-1:0]     ack_sync;
    logic                  ack_s;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ok_q, ok_d;
    logic                  done_q, done_d;
    logic                  terr_q, terr_d;
    logic [7:0]            count_q, count_d;

    // ack_dest is asynchronous; only the last stage of this chain feeds logic
    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_N-2:0], ack_dest};
        end
    end

    assign ack_s = ack_sync[SYNC_N-1];

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        done_d  = 1'b0;
        terr_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !ack_s) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    ok_d    = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // ack is checked first so it wins over a same-cycle timeout
                if (ack_s) begin
                    req_d   = 1'b0;
                    ok_d    = 1'b1;
                    state_d = ST_RELEASE;
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        req_d   = 1'b0;
                        ok_d    = 1'b0;
                        terr_d  = 1'b1;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                    if (ok_q) begin
                        done_d  = 1'b1;
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready    = (state_q == ST_IDLE) && !ack_s;
    assign busy        = (state_q != ST_IDLE);
    assign req_src     = req_q;
    assign data_src    = data_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign xfer_count  = count_q;

endmodule

// File: tb/tb_handshake_tx_src.sv
// tb/tb_handshake_tx_src.sv - randomized and directed checks of handshake_tx_src against a transaction-level model
`timescale 1ns/1ps
module tb_handshake_tx_src;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int TMO  = 8;

    logic          clk_src  = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          ack_dest = 1'b0;
    logic          in_ready, req_src, busy, done, timeout_err;
    logic [DW-1:0] data_src;
    logic [7:0]    xfer_count;

    handshake_tx_src #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk_src(clk_src), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ack_dest(ack_dest), .req_src(req_src), .data_src(data_src),
        .busy(busy), .done(done), .timeout_err(timeout_err), .xfer_count(xfer_count)
    );

    always #5 clk_src = ~clk_src;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: ack seen by the FSM is ack_dest delayed by SYNC edges;
    // a request expires TMO edges after its acceptance edge unless the delayed ack arrives.
    int       m_phase;      // 0 idle, 1 waiting for ack, 2 waiting for ack release
    bit       m_req, m_done, m_terr, m_ok;
    bit [7:0] m_data, m_cnt;
    longint   m_cyc, m_acc;
    bit       aq[$];

    task automatic model_reset();
        m_phase = 0; m_req = 0; m_done = 0; m_terr = 0; m_ok = 0;
        m_data = 0; m_cnt = 0; m_cyc = 0; m_acc = 0;
        aq.delete();
        for (int i = 0; i < SYNC; i++) aq.push_back(1'b0);
    endtask

    task automatic model_step();
        bit as;
        as     = aq[0];
        m_done = 0;
        m_terr = 0;
        m_cyc++;
        if (m_phase == 0) begin
            if (in_valid && !as) begin
                m_data = in_data; m_req = 1; m_acc = m_cyc; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (as) begin
                m_req = 0; m_ok = 1; m_phase = 2;
            end else if (m_cyc - m_acc == TMO) begin
                m_req = 0; m_ok = 0; m_terr = 1; m_phase = 2;
            end
        end else if (!as) begin
            m_phase = 0;
            if (m_ok) begin
                m_done = 1;
                m_cnt  = m_cnt + 8'd1;
            end
        end
        void'(aq.pop_front());
        aq.push_back(ack_dest);
    endtask

    always @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // per-cycle comparison plus event bookkeeping for the directed scenarios
    int       ncyc = 0;
    int       n_done = 0, n_terr = 0, req_hi = 0, stab_err = 0;
    bit       prev_req = 0;
    bit [7:0] prev_data = 0;
    bit [7:0] caps[$];
    int       rc[$];
    int       dq[$];

    always @(negedge clk_src) begin
        ncyc++;
        if (rst_n) begin
            chk("req_src",     32'(req_src),     32'(m_req));
            chk("data_src",    32'(data_src),    32'(m_data));
            chk("busy",        32'(busy),        32'(m_phase != 0));
            chk("in_ready",    32'(in_ready),    32'((m_phase == 0) && !aq[0]));
            chk("done",        32'(done),        32'(m_done));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            chk("xfer_count",  32'(xfer_count),  32'(m_cnt));
            if (done) begin n_done++; dq.push_back(ncyc); end
            if (timeout_err) n_terr++;
            if (req_src) req_hi++;
            if (req_src && !prev_req) begin caps.push_back(data_src); rc.push_back(ncyc); end
            if (req_src && prev_req && data_src != prev_data) stab_err++;
            prev_req  = req_src;
            prev_data = data_src;
        end else begin
            prev_req = 0;
        end
    end

    // destination responder; force_ack hands ack_dest to the directed stimulus
    bit force_ack = 1;
    bit rnd = 0;
    int r_st = 0, r_n = 0, d_up = 3, d_dn = 3;

    always @(negedge clk_src) begin
        if (force_ack || !rst_n) begin
            r_st = 0;
        end else begin
            case (r_st)
                0: if (req_src) begin
                    r_n = 0; r_st = 1;
                    if (rnd) begin d_up = int'($urandom_range(1, 9)); d_dn = int'($urandom_range(1, 4)); end
                end
                1: begin r_n++; if (r_n >= d_up) begin ack_dest = 1; r_st = 2; end end
                2: if (!req_src) begin r_n = 0; r_st = 3; end
                default: begin r_n++; if (r_n >= d_dn) begin ack_dest = 0; r_st = 0; end end
            endcase
        end
    end

    task automatic clear_mon();
        n_done = 0; n_terr = 0; req_hi = 0; stab_err = 0;
        caps.delete(); rc.delete(); dq.delete();
    endtask

    task automatic do_reset();
        in_valid  = 0;
        force_ack = 1;
        ack_dest  = 0;
        rst_n     = 0;
        repeat (2) @(negedge clk_src);
        #1 rst_n = 1;
        clear_mon();
    endtask

    task automatic offer(input bit [7:0] d, input bit drop);
        int n = 0;
        in_data  = d;
        in_valid = 1;
        while (!in_ready && n < 300) begin @(negedge clk_src); n++; end
        if (!in_ready) begin
            fails++;
            $display("FAIL offer_wait: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk_src);
        if (drop) in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || ack_dest || r_st != 0) && n < 400) begin @(negedge clk_src); n++; end
        if (n >= 400) begin
            fails++;
            $display("FAIL idle_wait: busy=%0b after %0d cycles, required 0", busy, n);
        end
        repeat (3) @(negedge clk_src);
        #1;
    endtask

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk_src);
        #1;
        chk("rst_req_src",  32'(req_src),     32'd0);
        chk("rst_data_src", 32'(data_src),    32'd0);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_done",     32'(done),        32'd0);
        chk("rst_terr",     32'(timeout_err), 32'd0);
        chk("rst_count",    32'(xfer_count),  32'd0);
        chk("rst_in_ready", 32'(in_ready),    32'd1);

        // basic transfer, ack 3 cycles after req and release 3 cycles after req falls
        do_reset();
        force_ack = 0; rnd = 0; d_up = 3; d_dn = 3;
        offer(8'hA5, 1);
        wait_idle();
        chk("basic_caps", 32'(caps.size()), 32'd1);
        chk("basic_data", 32'(caps[0]),     32'hA5);
        chk("basic_done", 32'(n_done),      32'd1);
        chk("basic_terr", 32'(n_terr),      32'd0);
        chk("basic_cnt",  32'(xfer_count),  32'd1);
        chk("basic_stab", 32'(stab_err),    32'd0);

        // back-to-back with in_valid held high
        do_reset();
        force_ack = 0;
        offer(8'h3C, 0);
        offer(8'h7F, 1);
        wait_idle();
        chk("b2b_caps",  32'(caps.size()),   32'd2);
        chk("b2b_d0",    32'(caps[0]),       32'h3C);
        chk("b2b_d1",    32'(caps[1]),       32'h7F);
        chk("b2b_cnt",   32'(xfer_count),    32'd2);
        chk("b2b_done",  32'(n_done),        32'd2);
        chk("b2b_order", 32'(rc[1] > dq[0]), 32'd1);
        chk("b2b_stab",  32'(stab_err),      32'd0);

        // timeout with ack tied low
        do_reset();
        offer(8'h55, 1);
        wait_idle();
        chk("tmo_req_cycles", 32'(req_hi),     32'd8);
        chk("tmo_terr",       32'(n_terr),     32'd1);
        chk("tmo_done",       32'(n_done),     32'd0);
        chk("tmo_cnt",        32'(xfer_count), 32'd0);
        chk("tmo_busy",       32'(busy),       32'd0);

        // ack reaches the FSM on the very edge the timeout expires: ack wins
        do_reset();
        offer(8'h66, 1);
        repeat (5) @(negedge clk_src);
        ack_dest = 1;
        repeat (6) @(negedge clk_src);
        ack_dest = 0;
        wait_idle();
        chk("sim_done", 32'(n_done),     32'd1);
        chk("sim_terr", 32'(n_terr),     32'd0);
        chk("sim_cnt",  32'(xfer_count), 32'd1);

        // one cycle later the timeout wins
        do_reset();
        offer(8'h67, 1);
        repeat (6) @(negedge clk_src);
        ack_dest = 1;
        repeat (6) @(negedge clk_src);
        ack_dest = 0;
        wait_idle();
        chk("late_done", 32'(n_done),     32'd0);
        chk("late_terr", 32'(n_terr),     32'd1);
        chk("late_cnt",  32'(xfer_count), 32'd0);

        // spurious ack in IDLE blocks acceptance
        do_reset();
        ack_dest = 1;
        repeat (3) @(negedge clk_src);
        in_data = 8'h77; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_src); #1;
            chk("spur_in_ready", 32'(in_ready), 32'd0);
            chk("spur_req_src",  32'(req_src),  32'd0);
        end
        ack_dest = 0;
        offer(8'h77, 1);
        #1;
        chk("spur_req_after",  32'(req_src),  32'd1);
        chk("spur_data_after", 32'(data_src), 32'h77);
        force_ack = 0; d_up = 1; d_dn = 1;
        wait_idle();
        chk("spur_cnt", 32'(xfer_count), 32'd1);

        // reset in the middle of a request
        do_reset();
        force_ack = 0; d_up = 1; d_dn = 1;
        offer(8'h11, 1);
        wait_idle();
        chk("rmid_cnt_before", 32'(xfer_count), 32'd1);
        force_ack = 1;
        offer(8'h22, 1);
        repeat (2) @(negedge clk_src);
        #2 rst_n = 0;
        #1;
        chk("rmid_req",  32'(req_src),    32'd0);
        chk("rmid_cnt",  32'(xfer_count), 32'd0);
        chk("rmid_busy", 32'(busy),       32'd0);
        @(negedge clk_src);
        #1 rst_n = 1;
        n_done = 0;
        repeat (20) @(negedge clk_src);
        #1;
        chk("rmid_no_done", 32'(n_done), 32'd0);

        // randomized traffic, responder delays straddle the timeout
        do_reset();
        force_ack = 0; rnd = 1;
        for (int i = 0; i < 200; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap != 0) begin
                in_valid = 0;
                repeat (gap) @(negedge clk_src);
            end
            offer(8'($urandom), 1'($urandom_range(0, 1)));
        end
        in_valid = 0;
        wait_idle();
        chk("rand_stab", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
